// File: rtl/dac_cmd_pkg.sv
// Shared types and constants for the DAC command arbiter.
// The init table is only referenced when DAC_INIT_SEQ_EN is defined.
package dac_cmd_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [7:0] CMD_GET_PFX = 8'h20;
    localparam logic [7:0] CMD_SET_PFX = 8'h21;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    localparam int INIT_LEN = 4;

    function automatic cmd_t init_entry(input int idx);
        cmd_t e;
        case (idx)
            0:       e = '{addr: {CMD_SET_PFX, 8'h01}, data: 16'h0000};
            1:       e = '{addr: {CMD_SET_PFX, 8'h02}, data: 16'h0003};
            2:       e = '{addr: {CMD_SET_PFX, 8'h03}, data: 16'h0080};
            3:       e = '{addr: {CMD_GET_PFX, 8'h00}, data: 16'h0000};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts after the last granted index.
// One-hot grant out, all-zero when nobody requests.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_i[j] && j == (int'(ptr_i) + k) % N) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dac_cmd_arbiter.sv
// Round-robin arbiter feeding one DAC command port with fixed spacing.
// Define DAC_INIT_SEQ_EN to replay the package init table after startup.
module dac_cmd_arbiter
    import dac_cmd_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int GAP_CYCLES     = 200,
    parameter int STARTUP_CYCLES = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [N_REQ-1:0]     req_valid_in,
    input  logic [16*N_REQ-1:0]  req_addr_in,
    input  logic [16*N_REQ-1:0]  req_data_in,
    output logic [N_REQ-1:0]     req_ready_out,
    output logic [N_REQ-1:0]     rsp_valid_out,
    output logic [15:0]          rsp_data_out,
    output logic                 busy_out,
    output logic                 cmd_trig_out,
    output logic [15:0]          cmd_addr_out,
    output logic [15:0]          cmd_data_out,
    input  logic [15:0]          cmd_data_in
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAXC = (GAP_CYCLES > STARTUP_CYCLES) ?
                          GAP_CYCLES : STARTUP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_dec;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt, gnt_q, gnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             init_q, init_d;
    logic             wait_done;

`ifdef DAC_INIT_SEQ_EN
    localparam int XW = $clog2(INIT_LEN + 1);
    logic [XW-1:0] idx_q, idx_d;
    cmd_t          ent;
`endif

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req_i (req_valid_in),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign cnt_dec   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    assign wait_done = (cnt_q <= CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        init_d  = init_q;
`ifdef DAC_INIT_SEQ_EN
        idx_d   = idx_q;
        ent     = init_entry(int'(idx_q));
`endif
        case (state_q)
            ST_STARTUP: begin
                cnt_d = cnt_dec;
                if (wait_done) begin
`ifdef DAC_INIT_SEQ_EN
                    state_d = ST_INIT;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_INIT: begin
`ifdef DAC_INIT_SEQ_EN
                if (idx_q == XW'(INIT_LEN)) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d  = ent.addr;
                    data_d  = ent.data;
                    idx_d   = idx_q + XW'(1);
                    gnt_d   = '0;
                    init_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (|gnt) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt[i]) begin
                            addr_d = req_addr_in[16*i +: 16];
                            data_d = req_data_in[16*i +: 16];
                            ptr_d  = IW'(i);
                        end
                    end
                    gnt_d   = gnt;
                    init_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The INIT cycle between table entries is part of their gap.
                cnt_d   = init_q ? CW'(GAP_CYCLES - 1) : CW'(GAP_CYCLES);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_dec;
                if (wait_done) begin
                    state_d = init_q ? ST_INIT : ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_STARTUP;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_STARTUP;
            cnt_q   <= CW'(STARTUP_CYCLES);
            ptr_q   <= IW'(N_REQ - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            init_q  <= 1'b0;
`ifdef DAC_INIT_SEQ_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            init_q  <= init_d;
`ifdef DAC_INIT_SEQ_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign req_ready_out = (state_q == ST_IDLE) ? gnt : '0;
    assign rsp_valid_out = (state_q == ST_RESP) ? gnt_q : '0;
    assign rsp_data_out  = (state_q == ST_RESP) ? cmd_data_in : '0;
    assign busy_out      = !rst_in && (state_q != ST_IDLE);
    assign cmd_trig_out  = (state_q == ST_ISSUE);
    assign cmd_addr_out  = addr_q;
    assign cmd_data_out  = data_q;

endmodule

// File: tb/tb_dac_cmd_arbiter.sv
// Randomized bench for dac_cmd_arbiter against a cycle-timeline model.
// Honours DAC_INIT_SEQ_EN the same way as the design.
module tb_dac_cmd_arbiter;
    import dac_cmd_pkg::*;

    localparam int N   = 2;
    localparam int GAP = 200;
    localparam int S   = 512;
`ifdef DAC_INIT_SEQ_EN
    localparam int IDLE_T   = S + 1 + INIT_LEN * (GAP + 1);
    localparam int IDLE_LIT = 1317;
    localparam int TRIG_LIT = 4;
`else
    localparam int IDLE_T   = S;
    localparam int IDLE_LIT = 512;
    localparam int TRIG_LIT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req_valid_in;
    logic [16*N-1:0] req_addr_in;
    logic [16*N-1:0] req_data_in;
    logic [N-1:0]    req_ready_out;
    logic [N-1:0]    rsp_valid_out;
    logic [15:0]     rsp_data_out;
    logic            busy_out;
    logic            cmd_trig_out;
    logic [15:0]     cmd_addr_out;
    logic [15:0]     cmd_data_out;
    logic [15:0]     cmd_data_in;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_cmd_arbiter #(
        .N_REQ          (N),
        .GAP_CYCLES     (GAP),
        .STARTUP_CYCLES (S)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_addr_in   (req_addr_in),
        .req_data_in   (req_data_in),
        .req_ready_out (req_ready_out),
        .rsp_valid_out (rsp_valid_out),
        .rsp_data_out  (rsp_data_out),
        .busy_out      (busy_out),
        .cmd_trig_out  (cmd_trig_out),
        .cmd_addr_out  (cmd_addr_out),
        .cmd_data_out  (cmd_data_out),
        .cmd_data_in   (cmd_data_in)
    );

    // model state
    int          t = 0;
    int          abs_cyc = 0;
    bit          rst_prev = 1'b0;
    bit          active = 1'b0;
    int          g_t, who;
    int          last = N - 1;
    logic [15:0] pend_a, pend_d;
    logic [15:0] exp_a = '0;
    logic [15:0] exp_d = '0;
    int          prints = 0;

    // observations of the DUT for the literal checks
    int          gq_t[$];
    int          gq_w[$];
    int          first_ready_t = -1;
    int          busy_low_t = -1;
    int          init_trigs = 0;
    int          last_trig_abs = -1;
    int          last_rsp_abs = -1;
    logic [N-1:0] last_rsp_v = '0;
    logic [15:0] last_rsp_d = '0;
    int          rsp_cnt = 0;

    always @(negedge clk) begin
        logic          e_busy, e_trig;
        logic [N-1:0]  e_rdy, e_rsp;
        logic [15:0]   e_rd;
        int            d, k, j;
        bit            ok;
        cmd_t          ent;
        abs_cyc++;
        if (rst_in) begin
            if (rst_prev) begin
                total++;
                if (busy_out || cmd_trig_out || req_ready_out != 0 ||
                    rsp_valid_out != 0 || cmd_addr_out != 0 ||
                    cmd_data_out != 0) begin
                    bad++;
                    $display("FAIL reset_zero got busy=%b trig=%b rdy=%b rsp=%b a=%h d=%h want all 0",
                             busy_out, cmd_trig_out, req_ready_out,
                             rsp_valid_out, cmd_addr_out, cmd_data_out);
                end
            end
            rst_prev = 1'b1;
            t = 0;
            active = 1'b0;
            last = N - 1;
            exp_a = '0;
            exp_d = '0;
            first_ready_t = -1;
            busy_low_t = -1;
            init_trigs = 0;
        end else begin
            rst_prev = 1'b0;
            e_busy = 1'b0;
            e_trig = 1'b0;
            e_rdy  = '0;
            e_rsp  = '0;
            e_rd   = '0;
            if (t < IDLE_T) begin
                e_busy = 1'b1;
`ifdef DAC_INIT_SEQ_EN
                if (t > S && (t - S - 1) % (GAP + 1) == 0) begin
                    k = (t - S - 1) / (GAP + 1);
                    if (k < INIT_LEN) begin
                        ent = init_entry(k);
                        e_trig = 1'b1;
                        exp_a = ent.addr;
                        exp_d = ent.data;
                    end
                end
`endif
            end else if (active && t - g_t <= GAP + 2) begin
                d = t - g_t;
                e_busy = 1'b1;
                if (d == 1) begin
                    e_trig = 1'b1;
                    exp_a = pend_a;
                    exp_d = pend_d;
                end
                if (d == GAP + 2) begin
                    e_rsp[who] = 1'b1;
                    e_rd = cmd_data_in;
                    active = 1'b0;
                end
            end else begin
                active = 1'b0;
                for (k = 1; k <= N; k++) begin
                    j = (last + k) % N;
                    if (!active && req_valid_in[j]) begin
                        active = 1'b1;
                        e_rdy[j] = 1'b1;
                        g_t = t;
                        who = j;
                        last = j;
                        pend_a = req_addr_in[16*j +: 16];
                        pend_d = req_data_in[16*j +: 16];
                    end
                end
            end
            total++;
            ok = (busy_out == e_busy) && (cmd_trig_out == e_trig) &&
                 (req_ready_out == e_rdy) && (rsp_valid_out == e_rsp) &&
                 (cmd_addr_out == exp_a) && (cmd_data_out == exp_d) &&
                 (e_rsp == 0 || rsp_data_out == e_rd);
            if (!ok) begin
                bad++;
                if (prints < 20) begin
                    prints++;
                    $display("FAIL cycle t=%0d got busy=%b trig=%b rdy=%b rsp=%b rd=%h a=%h d=%h want busy=%b trig=%b rdy=%b rsp=%b rd=%h a=%h d=%h",
                             t, busy_out, cmd_trig_out, req_ready_out,
                             rsp_valid_out, rsp_data_out, cmd_addr_out,
                             cmd_data_out, e_busy, e_trig, e_rdy, e_rsp,
                             e_rd, exp_a, exp_d);
                end
            end
            if (req_ready_out != 0) begin
                gq_t.push_back(abs_cyc);
                gq_w.push_back(req_ready_out[1] ? 1 : 0);
                if (first_ready_t < 0) first_ready_t = t;
            end
            if (cmd_trig_out) begin
                last_trig_abs = abs_cyc;
                if (t < IDLE_LIT) init_trigs++;
            end
            if (rsp_valid_out != 0) begin
                last_rsp_abs = abs_cyc;
                last_rsp_v = rsp_valid_out;
                last_rsp_d = rsp_data_out;
                rsp_cnt++;
            end
            if (!busy_out && busy_low_t < 0) busy_low_t = t;
            t++;
        end
    end

    task automatic check(input string nm, input longint got,
                         input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    bit rnd = 1'b1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) cmd_data_in = 16'($urandom);
        end
    endtask

    task automatic set_req(input int r, input logic [15:0] a,
                           input logic [15:0] dt);
        req_addr_in[16*r +: 16] = a;
        req_data_in[16*r +: 16] = dt;
    endtask

    task automatic wait_ready(input int r, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (req_ready_out[r]) seen = 1'b1;
        end
        check($sformatf("ready%0d_seen", r), seen, 1);
        @(posedge clk);
        #1;
        req_valid_in[r] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, rs0, c;
        logic [N-1:0] rdy;
        rst_in = 1'b1;
        req_valid_in = '0;
        req_addr_in = '0;
        req_data_in = '0;
        cmd_data_in = '0;
        tick(3);
        rst_in = 1'b0;

        set_req(0, 16'h2105, 16'h00A5);
        req_valid_in = 2'b01;
        wait_ready(0, IDLE_LIT + 20);
        tick(210);
        check("first_ready_t", first_ready_t, IDLE_LIT);
        check("busy_low_t", busy_low_t, IDLE_LIT);
        check("init_trigs", init_trigs, TRIG_LIT);
        check("grant_to_trig", last_trig_abs - gq_t[$], 1);
        check("trig_to_rsp", last_rsp_abs - last_trig_abs, 201);
        check("rsp_v_req0", last_rsp_v, 2'b01);

        rnd = 1'b0;
        cmd_data_in = 16'h0012;
        set_req(1, 16'h2005, 16'($urandom));
        req_valid_in = 2'b10;
        wait_ready(1, 20);
        tick(210);
        check("rsp_v_req1", last_rsp_v, 2'b10);
        check("rsp_d_req1", last_rsp_d, 16'h0012);
        rnd = 1'b1;

        n0 = gq_t.size();
        set_req(0, 16'h2111, 16'h1234);
        set_req(1, 16'h2122, 16'h5678);
        req_valid_in = 2'b11;
        tick(700);
        req_valid_in = '0;
        tick(220);
        check("alt_count", gq_t.size() - n0, 4);
        if (gq_t.size() - n0 == 4) begin
            check("alt_w0", gq_w[n0], 0);
            check("alt_w1", gq_w[n0 + 1], 1);
            check("alt_w2", gq_w[n0 + 2], 0);
            check("alt_w3", gq_w[n0 + 3], 1);
            for (int i = 1; i < 4; i++)
                check("alt_spacing", gq_t[n0 + i] - gq_t[n0 + i - 1], 203);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req_valid_in = N'($urandom);
            for (int r = 0; r < N; r++) begin
                c = $urandom_range(0, 2);
                set_req(r, c == 0 ? 16'($urandom) :
                           {(c == 1 ? CMD_GET_PFX : CMD_SET_PFX),
                            8'($urandom)}, 16'($urandom));
            end
            tick(1);
        end
        req_valid_in = '0;
        tick(220);

        rs0 = rsp_cnt;
        set_req(0, 16'h2133, 16'h0F0F);
        req_valid_in = 2'b01;
        wait_ready(0, 20);
        tick(51);
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
        req_valid_in = 2'b11;
        rdy = '0;
        for (int i = 0; i < IDLE_LIT + 20 && rdy == 0; i++) begin
            @(negedge clk);
            rdy = req_ready_out;
        end
        check("post_reset_grant", rdy, 2'b01);
        @(posedge clk);
        #1;
        req_valid_in = '0;
        tick(210);
        check("rsp_after_reset", rsp_cnt - rs0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_cmd_arbiter.md
DAC_CMD_ARBITER -- requirements
Module: dac_cmd_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of command requesters (2..4).
REQ-002 Parameter GAP_CYCLES, default 200, clk_in cycles reserved per command; covers one 16-bit SPI transfer at 10 MHz plus the DAC controller's state overhead.
REQ-003 Parameter STARTUP_CYCLES, default 512, hold-off after reset; covers the DAC controller's internal reset/SMP_DLY sequence.
REQ-004 clk_in  in  1  sole clock, 100 MHz.
REQ-005 rst_in  in  1  synchronous, active-high reset.
REQ-006 req_valid_in  in  N_REQ  per-requester command request.
REQ-007 req_addr_in  in  16*N_REQ  per-requester command address (16'h20xx get, 16'h21xx set).
REQ-008 req_data_in  in  16*N_REQ  per-requester command data.
REQ-009 req_ready_out  out  N_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-010 rsp_valid_out  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 rsp_data_out  out  16  read-back data, valid with rsp_valid_out.
REQ-012 busy_out  out  1  high in every state except IDLE.
REQ-013 cmd_trig_out  out  1  one-cycle trigger to the DAC command port.
REQ-014 cmd_addr_out  out  16  DAC command address.
REQ-015 cmd_data_out  out  16  DAC command data.
REQ-016 cmd_data_in  in  16  DAC read-back data.

Function
REQ-017 States: STARTUP, INIT, IDLE, ISSUE, WAIT, RESP.
- STARTUP -> INIT after STARTUP_CYCLES cycles.
- INIT -> IDLE when the init table is exhausted.
- IDLE -> ISSUE on a grant.
- ISSUE -> WAIT after one cycle.
- WAIT -> RESP, or back to INIT for init commands, after GAP_CYCLES cycles.
- RESP -> IDLE after one cycle.
REQ-018 req_ready_out is asserted only in IDLE, only to the single winning requester, and only when that requester's req_valid_in is high.
REQ-019 Arbitration is round-robin: the search starts at the index after the last granted requester and wraps from N_REQ-1 to 0; after reset requester 0 has top priority.
REQ-020 On a grant, the granted requester's addr and data are registered into cmd_addr_out and cmd_data_out and held unchanged until the following IDLE.
REQ-021 cmd_trig_out is high for exactly the ISSUE cycle, one cycle after the grant.
REQ-022 rsp_valid_out[granted] pulses exactly GAP_CYCLES+1 cycles after cmd_trig_out, with rsp_data_out equal to cmd_data_in sampled that cycle; it pulses for both get and set commands.
REQ-023 The next grant occurs no earlier than the cycle after RESP, giving a minimum command spacing of GAP_CYCLES+3 cycles.
REQ-024 A req_valid_in deasserted before its grant is dropped without effect; simultaneous requests are resolved solely by REQ-019.
REQ-025 Address values other than 16'h20xx and 16'h21xx are forwarded unchanged; the arbiter does not decode them.
REQ-026 The wait counter is sized to hold max(GAP_CYCLES, STARTUP_CYCLES) and decrements to zero without wrapping.

Reset
REQ-027 rst_in forces STARTUP, reloads the startup counter, resets the round-robin pointer, and zeroes every output; this applies also mid-command.
REQ-028 A command aborted by reset produces no rsp_valid_out, and the requester must re-request.

Configuration
REQ-029 With macro DAC_INIT_SEQ_EN defined, INIT issues each init-table entry in order with ISSUE/WAIT timing, with no rsp_valid_out and no requester grants until the table is done.
REQ-030 Without DAC_INIT_SEQ_EN, INIT lasts zero cycles and STARTUP goes directly to IDLE; the init table is not synthesized.

Structure
REQ-031 A shared package dac_cmd_pkg holds:
- the state enum;
- the command-address prefixes 8'h20 and 8'h21;
- the init-table length and entries (16-bit addr/data pairs, default 4 entries).
REQ-032 The round-robin grant logic is a sub-module rr_arbiter (request vector and pointer in, one-hot grant out); everything else is flat.

Verification
REQ-033 Reset release, macro off -> busy_out high for 512 cycles, then low; no cmd_trig_out during startup.
REQ-034 Macro on, 4-entry table -> 4 cmd_trig_out pulses spaced 201 cycles apart, with addr/data matching the table in order and no rsp_valid_out.
REQ-035 Requester 0 set {16'h2105, 16'h00A5} -> ready next-IDLE cycle, trig one cycle later, cmd_addr_out/cmd_data_out stable through WAIT, rsp_valid_out[0] 201 cycles after the trig.
REQ-036 Both requesters held valid -> grants alternate 0,1,0,1, spaced 203 cycles apart.
REQ-037 Requester 1 get 16'h2005 with cmd_data_in=16'h0012 at RESP -> rsp_data_out=16'h0012 with rsp_valid_out[1] only.
REQ-038 rst_in pulsed 50 cycles into WAIT -> all outputs 0, no rsp_valid_out, STARTUP restarts, and the next grant goes to requester 0.
